// File: rtl/core_ex_lsu_biu_if.sv
// Request/response bus between the EX-stage load/store unit and the BIU.
// The master side (LSU) issues requests; the slave side (BIU) answers them.
interface core_ex_lsu_biu_if #(
  parameter int XLEN = 32
);
  logic              biu_req_valid;
  logic              biu_req_ready;
  logic [XLEN-1:0]   biu_req_addr;
  logic              biu_req_wen;
  logic [XLEN-1:0]   biu_req_wdata;
  logic [XLEN/8-1:0] biu_req_wmask;
  logic              biu_rsp_valid;
  logic [XLEN-1:0]   biu_rsp_rdata;
  logic              biu_rsp_err;

  modport master (
    output biu_req_valid, biu_req_addr, biu_req_wen, biu_req_wdata, biu_req_wmask,
    input  biu_req_ready, biu_rsp_valid, biu_rsp_rdata, biu_rsp_err
  );

  modport slave (
    input  biu_req_valid, biu_req_addr, biu_req_wen, biu_req_wdata, biu_req_wmask,
    output biu_req_ready, biu_rsp_valid, biu_rsp_rdata, biu_rsp_err
  );
endinterface

// File: rtl/core_ex_lsu_biu.sv
// EX-stage load/store unit: one op in flight, byte-lane alignment, strobes and
// load extension, with misalign / bus-error / timeout reported as flags.
module core_ex_lsu_biu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic            i_load,
  input  logic            i_store,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_write_data,
  output logic            valid_out,
  input  logic            ready_out,
  output logic [XLEN-1:0] read_data,
  output logic            exc_misalign,
  output logic            exc_bus,
  core_ex_lsu_biu_if.master biu
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CNTW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              is_load_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [OFFW-1:0]   off_q;
  logic [CNTW-1:0]   cnt;

  logic              is_mem;
  logic              misalign;
  logic              timeout_hit;
  logic [OFFW-1:0]   in_off;
  logic [XLEN-1:0]   lane_wdata;
  logic [NB-1:0]     mask_base;
  logic [NB-1:0]     lane_wmask;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   low_mask;
  logic              sign_bit;
  logic [XLEN-1:0]   load_ext;

  assign ready_in    = (state == IDLE);
  assign valid_out   = (state == DONE);
  assign is_mem      = i_load | i_store;
  assign in_off      = i_mem_addr[OFFW-1:0];
  assign timeout_hit = (cnt == CNTW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    misalign = 1'b0;
    case (i_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = i_mem_addr[0];
      2'd2:    misalign = |i_mem_addr[1:0];
      default: misalign = (XLEN == 32) ? 1'b1 : (|i_mem_addr[2:0]);
    endcase
  end

  // Store data is replicated across every lane so the BIU only needs the strobes.
  always_comb begin
    lane_wdata = i_write_data;
    mask_base  = NB'(255);
    case (i_size)
      2'd0: begin
        lane_wdata = {NB{i_write_data[7:0]}};
        mask_base  = NB'(1);
      end
      2'd1: begin
        lane_wdata = {(NB/2){i_write_data[15:0]}};
        mask_base  = NB'(3);
      end
      2'd2: begin
        lane_wdata = {(XLEN/32){i_write_data[31:0]}};
        mask_base  = NB'(15);
      end
      default: ;
    endcase
    lane_wmask = mask_base << in_off;
  end

  // Extension by masking keeps the word case width-safe when XLEN is 32.
  always_comb begin
    shifted  = biu.biu_rsp_rdata >> {off_q, 3'b000};
    low_mask = '1;
    sign_bit = shifted[XLEN-1];
    case (size_q)
      2'd0: begin
        low_mask = {{(XLEN-8){1'b0}}, 8'hFF};
        sign_bit = shifted[7];
      end
      2'd1: begin
        low_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
        sign_bit = shifted[15];
      end
      2'd2: begin
        low_mask = {XLEN{1'b1}} >> (XLEN - 32);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    load_ext = (shifted & low_mask) | ((sign_bit & ~unsigned_q) ? ~low_mask : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_in) state_nxt = (!is_mem || misalign) ? DONE : REQ;
      REQ:  if (biu.biu_req_ready) state_nxt = WAIT;
      WAIT: if (biu.biu_rsp_valid || timeout_hit) state_nxt = DONE;
      DONE: if (ready_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses outside WAIT never reach these registers, so late beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load_q         <= 1'b0;
      size_q            <= 2'd0;
      unsigned_q        <= 1'b0;
      off_q             <= '0;
      cnt               <= '0;
      read_data         <= '0;
      exc_misalign      <= 1'b0;
      exc_bus           <= 1'b0;
      biu.biu_req_valid <= 1'b0;
      biu.biu_req_addr  <= '0;
      biu.biu_req_wen   <= 1'b0;
      biu.biu_req_wdata <= '0;
      biu.biu_req_wmask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            is_load_q         <= i_load & ~i_store;
            size_q            <= i_size;
            unsigned_q        <= i_unsigned;
            off_q             <= in_off;
            read_data         <= '0;
            exc_misalign      <= is_mem & misalign;
            exc_bus           <= 1'b0;
            biu.biu_req_valid <= is_mem & ~misalign;
            biu.biu_req_addr  <= {i_mem_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            biu.biu_req_wen   <= i_store;
            biu.biu_req_wdata <= lane_wdata;
            biu.biu_req_wmask <= i_store ? lane_wmask : '0;
          end
        end
        REQ: begin
          if (biu.biu_req_ready) begin
            biu.biu_req_valid <= 1'b0;
            cnt               <= '0;
          end
        end
        WAIT: begin
          if (biu.biu_rsp_valid) begin
            exc_bus <= biu.biu_rsp_err;
            if (is_load_q && !biu.biu_rsp_err) read_data <= load_ext;
          end else if (timeout_hit) begin
            exc_bus <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ex_lsu_biu.sv
// Randomized scoreboard bench for core_ex_lsu_biu with a reactive BIU model
// and a byte-level reference model of alignment, strobes and extension.
module tb_core_ex_lsu_biu;

  localparam int XLEN = 32;
  localparam int T    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in, ready_in, i_load, i_store, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_mem_addr, i_write_data;
  logic        valid_out, ready_out;
  logic [31:0] read_data;
  logic        exc_misalign, exc_bus;

  core_ex_lsu_biu_if #(.XLEN(XLEN)) bus ();

  core_ex_lsu_biu #(.XLEN(XLEN), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .i_load       (i_load),
    .i_store      (i_store),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_mem_addr   (i_mem_addr),
    .i_write_data (i_write_data),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .read_data    (read_data),
    .exc_misalign (exc_misalign),
    .exc_bus      (exc_bus),
    .biu          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        be;
    int          lat;
    int          hold;
    int          acceptCyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          reqWait;
    int          rspDelay;
    logic        err;
    logic        noRsp;
    logic [31:0] rdata;
  } req_t;

  exp_t expQ[$];
  req_t reqQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: work byte-by-byte on the bus word, then sign-extend arithmetically.
  function automatic void refModel(input logic ld, input logic st, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                   input int reqWait, input int rspDelay, input logic err,
                                   input logic noRsp, input logic [31:0] rdata,
                                   output exp_t e, output req_t r, output logic issues);
    int     nb  = 1 << sz;
    int     off = int'(addr % 4);
    logic   mem = ld | st;
    longint v;
    e = '{rd: 32'h0, mis: 1'b0, be: 1'b0, lat: 1, hold: 0, acceptCyc: 0};
    r = '{addr: 32'h0, wen: 1'b0, wdata: 32'h0, wmask: 4'h0, reqWait: reqWait,
          rspDelay: rspDelay, err: err, noRsp: noRsp, rdata: rdata};
    issues = 1'b0;
    if (mem && (sz == 2'd3 || (addr % nb) != 0)) begin
      e.mis = 1'b1;
    end else if (mem) begin
      issues = 1'b1;
      r.addr = addr - off;
      r.wen  = st;
      if (st) begin
        for (int j = 0; j < 4; j++) begin
          r.wdata[8*j +: 8] = wd[8*(j % nb) +: 8];
          if (j >= off && j < off + nb) r.wmask[j] = 1'b1;
        end
      end
      if (noRsp) begin
        e.be  = 1'b1;
        e.lat = 2 + reqWait + T;
      end else begin
        e.be  = err;
        e.lat = 3 + reqWait + rspDelay;
        if (!st && !err) begin
          v = 0;
          for (int i = 0; i < nb; i++) v += longint'(rdata[8*(off+i) +: 8]) << (8*i);
          if (!uns && v >= (longint'(1) << (8*nb - 1))) v -= longint'(1) << (8*nb);
          e.rd = v[31:0];
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, input int reqWait,
                               input int rspDelay, input logic err, input logic noRsp,
                               input logic [31:0] rdata, input int hold);
    int   waited = 0;
    exp_t e;
    req_t r;
    logic issues;
    @(negedge clk);
    while (!ready_in && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_in_wait", ready_in, 1);
    if (!ready_in) return;
    refModel(ld, st, sz, uns, addr, wd, reqWait, rspDelay, err, noRsp, rdata, e, r, issues);
    i_load = ld; i_store = st; i_size = sz; i_unsigned = uns;
    i_mem_addr = addr; i_write_data = wd;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    i_load = 1'($urandom); i_store = 1'($urandom); i_size = 2'($urandom);
    i_mem_addr = $urandom; i_write_data = $urandom;
    e.acceptCyc = cyc;
    e.hold = hold;
    if (issues) reqQ.push_back(r);
    expQ.push_back(e);
  endtask

  // Monitor: compares every DONE cycle against the head entry and owns ready_out.
  initial begin
    exp_t e;
    int   obs = 0;
    ready_out = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ready_out = 1'b0;
        obs = 0;
        continue;
      end
      if (valid_out) begin
        checkOutput("valid_expected", expQ.size() > 0, 1);
        if (expQ.size() == 0) begin
          ready_out = 1'b1;
        end else begin
          e = expQ[0];
          if (obs == 0) checkOutput("latency", cyc - e.acceptCyc + 1, e.lat);
          checkOutput("read_data", read_data, e.rd);
          checkOutput("exc_misalign", exc_misalign, e.mis);
          checkOutput("exc_bus", exc_bus, e.be);
          checkOutput("ready_in_done", ready_in, 0);
          obs++;
          if (obs > e.hold) begin
            ready_out = 1'b1;
            void'(expQ.pop_front());
            obs = 0;
          end else begin
            ready_out = 1'b0;
          end
        end
      end else begin
        ready_out = 1'b0;
      end
    end
  end

  // BIU model: checks the request payload while it is pending, then answers late, with error, or never.
  initial begin
    req_t cur;
    int   phase = 0;
    int   cnt = 0;
    bus.biu_req_ready = 1'b0;
    bus.biu_rsp_valid = 1'b0;
    bus.biu_rsp_rdata = '0;
    bus.biu_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      bus.biu_req_ready = 1'b0;
      bus.biu_rsp_valid = 1'b0;
      bus.biu_rsp_err   = 1'b0;
      bus.biu_rsp_rdata = $urandom;
      if (!rst_n) begin
        phase = 0;
        continue;
      end
      if (phase == 0 && bus.biu_req_valid) begin
        checkOutput("req_expected", reqQ.size() > 0, 1);
        if (reqQ.size() > 0) begin
          cur = reqQ.pop_front();
        end else begin
          cur = '{addr: bus.biu_req_addr, wen: bus.biu_req_wen, wdata: bus.biu_req_wdata,
                  wmask: bus.biu_req_wmask, reqWait: 0, rspDelay: 0, err: 1'b1,
                  noRsp: 1'b0, rdata: 32'h0};
        end
        cnt = cur.reqWait;
        phase = 1;
      end else if (phase == 0) begin
        bus.biu_rsp_valid = ($urandom_range(0, 9) == 0);
        bus.biu_rsp_err   = 1'($urandom);
      end
      if (phase == 1) begin
        checkOutput("req_valid_held", bus.biu_req_valid, 1);
        checkOutput("req_addr", bus.biu_req_addr, cur.addr);
        checkOutput("req_wen", bus.biu_req_wen, cur.wen);
        checkOutput("req_wmask", bus.biu_req_wmask, cur.wmask);
        if (cur.wen) checkOutput("req_wdata", bus.biu_req_wdata, cur.wdata);
        if (cnt == 0) begin
          bus.biu_req_ready = 1'b1;
          phase = 2;
          cnt = cur.noRsp ? T : cur.rspDelay;
        end else begin
          cnt--;
        end
      end else if (phase == 2) begin
        if (cnt == 0) begin
          bus.biu_rsp_valid = 1'b1;
          bus.biu_rsp_rdata = cur.noRsp ? $urandom : cur.rdata;
          bus.biu_rsp_err   = cur.noRsp ? 1'b0 : cur.err;
          phase = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    int          r, hold, rw, rd;
    logic        ld, st, uns, err, noRsp;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          waited;
    valid_in = 1'b0; i_load = 1'b0; i_store = 1'b0; i_size = 2'd0; i_unsigned = 1'b0;
    i_mem_addr = '0; i_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready_in", ready_in, 1);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_req_valid", bus.biu_req_valid, 0);
    checkOutput("rst_req_wen", bus.biu_req_wen, 0);
    checkOutput("rst_req_wmask", bus.biu_req_wmask, 0);
    checkOutput("rst_read_data", read_data, 0);
    checkOutput("rst_exc_misalign", exc_misalign, 0);
    checkOutput("rst_exc_bus", exc_bus, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1, 0, 2, 0, 32'h1000_0004, 32'h0, 0, 2, 0, 0, 32'h8000_00FF, 0);
    applyStimulus(1, 0, 0, 0, 32'h2000_0003, 32'h0, 0, 0, 0, 0, 32'h80AA_BBCC, 0);
    applyStimulus(1, 0, 0, 1, 32'h2000_0003, 32'h0, 1, 0, 0, 0, 32'h80AA_BBCC, 0);
    applyStimulus(0, 1, 1, 0, 32'h3000_0002, 32'h1234_ABCD, 0, 0, 0, 0, 32'h5555_5555, 0);
    applyStimulus(1, 0, 2, 0, 32'h4000_0001, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 3, 0, 32'h4000_0008, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 2, 0, 32'h5000_0000, 32'h0, 0, 0, 0, 1, 32'h0, 0);
    applyStimulus(1, 0, 1, 0, 32'h6000_0006, 32'h0, 2, 1, 0, 0, 32'hBEEF_1234, 3);
    applyStimulus(1, 0, 1, 1, 32'h6000_000A, 32'h0, 1, 1, 1, 0, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 1, 0, 0, 32'h7000_0001, 32'h0000_00A5, 0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 2, 0, 32'h7000_0003, 32'h1111_1111, 0, 0, 0, 0, 32'h0, 1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      ld = (r < 45) || (r >= 80 && r < 85);
      st = (r >= 45 && r < 85);
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % (1 << sz));
      rw = $urandom_range(0, 3);
      rd = $urandom_range(0, T - 1);
      err = ($urandom_range(0, 9) == 0);
      noRsp = ($urandom_range(0, 11) == 0);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(ld, st, sz, uns, addr, $urandom, rw, rd, err, noRsp, $urandom, hold);
    end

    applyStimulus(1, 0, 2, 0, 32'h0800_0010, 32'h0, 0, 0, 0, 1, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ready_in", ready_in, 1);
    checkOutput("async_rst_valid_out", valid_out, 0);
    checkOutput("async_rst_req_valid", bus.biu_req_valid, 0);
    checkOutput("async_rst_read_data", read_data, 0);
    checkOutput("async_rst_exc_misalign", exc_misalign, 0);
    checkOutput("async_rst_exc_bus", exc_bus, 0);
    expQ.delete();
    reqQ.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    applyStimulus(1, 0, 1, 0, 32'h0900_0002, 32'h0, 0, 0, 0, 0, 32'h8001_7FFF, 0);
    waited = 0;
    while (expQ.size() != 0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain", expQ.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
